// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared encodings for the calc control unit and datapath
package calc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CLR  = 3'd1,
        ST_LDA  = 3'd2,
        ST_LDB  = 3'd3,
        ST_EXEC = 3'd4,
        ST_OUT  = 3'd5
    } state_e;

    // Input-mux selects for the register-file write port
    localparam int SEL_IN1  = 0;
    localparam int SEL_IN2  = 1;
    localparam int SEL_ZERO = 2;
    localparam int SEL_ALU  = 3;

    localparam int ALU_ADD = 0;
    localparam int ALU_SUB = 1;
    localparam int ALU_AND = 2;
    localparam int ALU_OR  = 3;

    localparam int R0 = 0;
    localparam int R1 = 1;
    localparam int R2 = 2;
    localparam int R3 = 3;

endpackage

// File: rtl/calc_dp.sv
// rtl/calc_dp.sv - register file, input mux, ALU and output mux
module calc_dp
    import calc_pkg::*;
#(
    parameter int addr_size = 2,
    parameter int data_w    = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [data_w-1:0]    in1,
    input  logic [data_w-1:0]    in2,
    input  logic [addr_size-1:0] s1,
    input  logic [addr_size-1:0] wa,
    input  logic                 we,
    input  logic [addr_size-1:0] raa,
    input  logic [addr_size-1:0] rab,
    input  logic                 rea,
    input  logic                 reb,
    input  logic [addr_size-1:0] c,
    input  logic                 s2,
    output logic [data_w-1:0]    out
);

    logic [data_w-1:0] rf_q [2**addr_size];
    logic [data_w-1:0] rd_a, rd_b, alu_y, wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**addr_size; i++) rf_q[i] <= '0;
        end else if (we) begin
            rf_q[wa] <= wdata;
        end
    end

    always_comb begin
        rd_a = rea ? rf_q[raa] : '0;
        rd_b = reb ? rf_q[rab] : '0;
        case (int'(c))
            ALU_SUB: alu_y = rd_a - rd_b;
            ALU_AND: alu_y = rd_a & rd_b;
            ALU_OR:  alu_y = rd_a | rd_b;
            default: alu_y = rd_a + rd_b;
        endcase
        case (int'(s1))
            SEL_IN1:  wdata = in1;
            SEL_IN2:  wdata = in2;
            SEL_ALU:  wdata = alu_y;
            default:  wdata = '0;
        endcase
        out = s2 ? '0 : alu_y;
    end

endmodule

// File: rtl/calc_top.sv
// rtl/calc_top.sv - control unit joined to the datapath by matching signal names
module calc_top
    import calc_pkg::*;
#(
    parameter int addr_size = 2,
    parameter int data_w    = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 go,
    input  logic                 acc,
    input  logic [addr_size-1:0] op,
    input  logic [data_w-1:0]    in1,
    input  logic [data_w-1:0]    in2,
    output logic [data_w-1:0]    out,
    output logic                 busy,
    output logic                 done
);

    logic [addr_size-1:0] s1, wa, raa, rab, c;
    logic                 we, rea, reb, s2;

    calc_ctrl #(.addr_size(addr_size)) u_ctrl (
        .clk(clk), .rst_n(rst_n), .go(go), .acc(acc), .op(op),
        .s1(s1), .wa(wa), .we(we), .raa(raa), .rab(rab), .rea(rea), .reb(reb),
        .c(c), .s2(s2), .busy(busy), .done(done)
    );

    calc_dp #(.addr_size(addr_size), .data_w(data_w)) u_dp (
        .clk(clk), .rst_n(rst_n), .in1(in1), .in2(in2),
        .s1(s1), .wa(wa), .we(we), .raa(raa), .rab(rab), .rea(rea), .reb(reb),
        .c(c), .s2(s2), .out(out)
    );

endmodule

// File: rtl/calc_ctrl.sv
// rtl/calc_ctrl.sv - Moore control FSM sequencing clear/load/execute/output steps
module calc_ctrl
    import calc_pkg::*;
#(
    parameter int addr_size = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 go,
    input  logic                 acc,
    input  logic [addr_size-1:0] op,
    output logic [addr_size-1:0] s1,
    output logic [addr_size-1:0] wa,
    output logic                 we,
    output logic [addr_size-1:0] raa,
    output logic [addr_size-1:0] rab,
    output logic                 rea,
    output logic                 reb,
    output logic [addr_size-1:0] c,
    output logic                 s2,
    output logic                 busy,
    output logic                 done
);

    state_e                 state_q, state_d;
    logic [addr_size-1:0]   op_q, op_d;
    logic                   acc_q, acc_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            acc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
        end
    end

    // op/acc are captured only on acceptance so later input changes cannot disturb a run
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        acc_d   = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    state_d = ST_CLR;
                    op_d    = op;
                    acc_d   = acc;
                end
            end
            ST_CLR:  state_d = acc_q ? ST_LDB : ST_LDA;
            ST_LDA:  state_d = ST_LDB;
            ST_LDB:  state_d = ST_EXEC;
            ST_EXEC: state_d = ST_OUT;
            ST_OUT:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        s1   = '0;
        wa   = '0;
        we   = 1'b0;
        raa  = '0;
        rab  = '0;
        rea  = 1'b0;
        reb  = 1'b0;
        c    = '0;
        s2   = 1'b1;
        busy = (state_q != ST_IDLE);
        done = 1'b0;
        case (state_q)
            ST_CLR: begin
                s1 = addr_size'(SEL_ZERO);
                wa = addr_size'(R0);
                we = 1'b1;
            end
            ST_LDA: begin
                s1 = addr_size'(SEL_IN1);
                wa = addr_size'(R1);
                we = 1'b1;
            end
            ST_LDB: begin
                s1 = addr_size'(SEL_IN2);
                wa = addr_size'(R2);
                we = 1'b1;
            end
            ST_EXEC: begin
                rea = 1'b1;
                raa = acc_q ? addr_size'(R3) : addr_size'(R1);
                reb = 1'b1;
                rab = addr_size'(R2);
                c   = op_q;
                s1  = addr_size'(SEL_ALU);
                wa  = addr_size'(R3);
                we  = 1'b1;
            end
            // R3 + R0 (which holds zero) presents the stored result on the output
            ST_OUT: begin
                rea  = 1'b1;
                raa  = addr_size'(R3);
                reb  = 1'b1;
                rab  = addr_size'(R0);
                c    = addr_size'(ALU_ADD);
                s2   = 1'b0;
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
